// File: rtl/fetch_issue_ctrl_pkg.sv
// Shared definitions for the fetch/issue controller: widths, instruction family
// indices, ARM condition codes and the controller state encoding.
package fetch_issue_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FAM_W   = 16;
  localparam int unsigned SKIP_W  = 16;

  // Bit positions in the one-hot family vector
  localparam int unsigned FAM_DP_ISH  = 0;
  localparam int unsigned FAM_DP_RSH  = 1;
  localparam int unsigned FAM_MUL     = 2;
  localparam int unsigned FAM_SWP     = 3;
  localparam int unsigned FAM_HALF    = 4;
  localparam int unsigned FAM_DP_IMM  = 5;
  localparam int unsigned FAM_LS_IMM  = 6;
  localparam int unsigned FAM_LS_REG  = 7;
  localparam int unsigned FAM_LDM_STM = 8;
  localparam int unsigned FAM_BRANCH  = 9;
  localparam int unsigned FAM_COPROC  = 10;
  localparam int unsigned FAM_SWI     = 11;
  localparam int unsigned FAM_UNDEF   = 12;
  localparam int unsigned FAM_BX      = 13;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_COND  = 2'd1,
    ST_ISSUE = 2'd2
  } fic_state_t;

endpackage

// File: rtl/arm_cond_eval.sv
// ARM condition-field evaluator: decides whether an instruction executes given NZCV.
module arm_cond_eval
  import fetch_issue_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass_c
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // The NV encoding is never executed
  always_comb begin
    pass_c = 1'b0;
    case (cond)
      COND_EQ: pass_c = z;
      COND_NE: pass_c = !z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = !c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = !n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = !v;
      COND_HI: pass_c = c && !z;
      COND_LS: pass_c = !c || z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = !z && (n == v);
      COND_LE: pass_c = z || (n != v);
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue sequencer for the microcoded core: fetches into IR, checks the
// condition field, classifies the instruction family and holds it until uc_done.
module fetch_issue_ctrl
  import fetch_issue_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_0000)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic [3:0]          nzcv,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_val,
  input  logic                uc_done,
  output logic                issue_valid,
  output logic [INSTR_W-1:0]  ir,
  output logic [FAM_W-1:0]    family_bits,
  output logic [ADDR_W-1:0]   pc,
  output logic [SKIP_W-1:0]   skip_cnt
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [SKIP_W-1:0] SKIP_MAX   = '1;

  // Priority-ordered family decode; unmatched encodings outside the coprocessor
  // space fall into UNDEF so exactly one bit is always set.
  function automatic logic [FAM_W-1:0] classify(input logic [27:4] w);
    logic [FAM_W-1:0] f;
    f = '0;
    if (w[27:4] == 24'h12FFF1)                                           f[FAM_BX]      = 1'b1;
    else if (w[27:23] == 5'b00010 && w[21:20] == 2'b00 && w[11:4] == 8'h09) f[FAM_SWP]   = 1'b1;
    else if (w[27:24] == 4'b0000 && w[7:4] == 4'b1001)                   f[FAM_MUL]     = 1'b1;
    else if (w[27:25] == 3'b000 && w[7] && w[4] && w[6:5] != 2'b00)      f[FAM_HALF]    = 1'b1;
    else if (w[27:25] == 3'b000 && !w[7] && w[4])                        f[FAM_DP_RSH]  = 1'b1;
    else if (w[27:25] == 3'b000 && !w[4])                                f[FAM_DP_ISH]  = 1'b1;
    else if (w[27:25] == 3'b001)                                         f[FAM_DP_IMM]  = 1'b1;
    else if (w[27:25] == 3'b010)                                         f[FAM_LS_IMM]  = 1'b1;
    else if (w[27:25] == 3'b011 && w[4])                                 f[FAM_UNDEF]   = 1'b1;
    else if (w[27:25] == 3'b011)                                         f[FAM_LS_REG]  = 1'b1;
    else if (w[27:25] == 3'b100)                                         f[FAM_LDM_STM] = 1'b1;
    else if (w[27:25] == 3'b101)                                         f[FAM_BRANCH]  = 1'b1;
    else if (w[27:24] == 4'b1111)                                        f[FAM_SWI]     = 1'b1;
    else if (w[27:26] == 2'b11)                                          f[FAM_COPROC]  = 1'b1;
    else                                                                 f[FAM_UNDEF]   = 1'b1;
    return f;
  endfunction

  fic_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   pc_d;
  logic [INSTR_W-1:0]  ir_d;
  logic [SKIP_W-1:0]   skip_d;
  logic                redirect_pend, pend_d;
  logic [ADDR_W-1:0]   redirect_tgt, tgt_d;
  logic                req_d;
  logic                issue_d;
  logic [FAM_W-1:0]    fam_d;
  logic                cond_pass_c;
  logic                fetch_ack_c;
  logic [ADDR_W-1:0]   load_tgt_c;

  arm_cond_eval u_cond (
    .cond   (ir[31:28]),
    .nzcv   (nzcv),
    .pass_c (cond_pass_c)
  );

  // An ack only counts against a request that is actually on the bus
  assign fetch_ack_c = imem_req & imem_ack;
  assign load_tgt_c  = pc_load_val & ALIGN_MASK;
  assign imem_addr   = pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    ir_d    = ir;
    skip_d  = skip_cnt;
    pend_d  = redirect_pend;
    tgt_d   = redirect_tgt;
    case (state_q)
      ST_FETCH: begin
        if (fetch_ack_c) begin
          if (pc_load) begin
            pc_d   = load_tgt_c;
            pend_d = 1'b0;
          end else if (redirect_pend) begin
            pc_d   = redirect_tgt;
            pend_d = 1'b0;
          end else begin
            ir_d    = imem_rdata;
            pc_d    = pc + PC_STEP;
            state_d = ST_COND;
          end
        end else if (pc_load) begin
          // Address must stay stable mid-request, so park the target
          tgt_d  = load_tgt_c;
          pend_d = 1'b1;
        end
      end
      ST_COND: begin
        if (cond_pass_c) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_FETCH;
          if (skip_cnt != SKIP_MAX) skip_d = skip_cnt + SKIP_W'(1);
        end
        if (pc_load) pc_d = load_tgt_c;
      end
      ST_ISSUE: begin
        if (uc_done) state_d = ST_FETCH;
        if (pc_load) pc_d = load_tgt_c;
      end
      default: state_d = ST_FETCH;
    endcase
    req_d   = (state_d == ST_FETCH);
    issue_d = (state_d == ST_ISSUE);
    fam_d   = issue_d ? classify(ir_d[27:4]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc            <= RESET_VECTOR;
      ir            <= '0;
      skip_cnt      <= '0;
      redirect_pend <= 1'b0;
      redirect_tgt  <= '0;
      imem_req      <= 1'b0;
      issue_valid   <= 1'b0;
      family_bits   <= '0;
    end else begin
      state_q       <= state_d;
      pc            <= pc_d;
      ir            <= ir_d;
      skip_cnt      <= skip_d;
      redirect_pend <= pend_d;
      redirect_tgt  <= tgt_d;
      imem_req      <= req_d;
      issue_valid   <= issue_d;
      family_bits   <= fam_d;
    end
  end

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed self-checking bench for fetch_issue_ctrl.
module tb_fetch_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [3:0]  nzcv;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        uc_done;
  logic        issue_valid;
  logic [31:0] ir;
  logic [15:0] family_bits;
  logic [31:0] pc;
  logic [15:0] skip_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc;
  logic [15:0] exp_skip;

  logic [31:0] sw_word [12] = '{32'hE0000291, 32'hE12FFF10, 32'hE1000091, 32'hE1D000B0,
                                32'hE6000010, 32'hEF000000, 32'hE5900000, 32'hE7900000,
                                32'hE8BD0000, 32'hEE000000, 32'hE0800000, 32'hE0800010};
  logic [15:0] sw_fam  [12] = '{16'h0004, 16'h2000, 16'h0008, 16'h0010,
                                16'h1000, 16'h0800, 16'h0040, 16'h0080,
                                16'h0100, 16'h0400, 16'h0001, 16'h0002};

  logic [3:0]  cv_cond [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hC, 4'hD, 4'hE};
  logic [3:0]  cv_nzcv [16] = '{4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0010,
                                4'b0110, 4'b0000, 4'b1001, 4'b1000, 4'b0000, 4'b0100, 4'b0001, 4'b1111};
  logic        cv_pass [16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  fetch_issue_ctrl #(.ADDR_W(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .nzcv        (nzcv),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .uc_done     (uc_done),
    .issue_valid (issue_valid),
    .ir          (ir),
    .family_bits (family_bits),
    .pc          (pc),
    .skip_cnt    (skip_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) step();
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic finish_issue();
    uc_done = 1'b1;
    step();
    uc_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; nzcv = 4'h0;
    pc_load = 1'b0; pc_load_val = 32'h0; uc_done = 1'b0;
    exp_skip = 16'h0;

    // reset state
    @(negedge clk);
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_issue", 32'(issue_valid), 32'd0);
    chk("rst_fam",   32'(family_bits), 32'd0);
    chk("rst_pc",    pc,               32'h0);
    chk("rst_skip",  32'(skip_cnt),    32'd0);
    chk("rst_ir",    ir,               32'h0);
    rst_n = 1'b1;
    #1 chk("rel_req_pre", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("rel_req",  32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr,     32'h0);

    // DP immediate with two wait cycles
    step();
    chk("t2_w1_req",  32'(imem_req), 32'd1);
    chk("t2_w1_addr", imem_addr,     32'h0);
    step();
    chk("t2_w2_addr", imem_addr,     32'h0);
    fetch(32'hE3A00001, 0);
    chk("t2_cond_req",   32'(imem_req),    32'd0);
    chk("t2_cond_issue", 32'(issue_valid), 32'd0);
    chk("t2_ir",         ir,               32'hE3A00001);
    chk("t2_pc",         pc,               32'h4);
    step();
    chk("t2_issue", 32'(issue_valid), 32'd1);
    chk("t2_fam",   32'(family_bits), 32'h0020);
    step();
    chk("t2_hold_issue", 32'(issue_valid), 32'd1);
    chk("t2_hold_req",   32'(imem_req),    32'd0);
    finish_issue();
    chk("t2_done_issue", 32'(issue_valid), 32'd0);
    chk("t2_done_fam",   32'(family_bits), 32'd0);
    chk("t2_done_req",   32'(imem_req),    32'd1);
    chk("t2_done_addr",  imem_addr,        32'h4);
    exp_pc = 32'h4;

    // BEQ fails with Z=0, passes with Z=1
    nzcv = 4'b0000;
    fetch(32'h0A000000, 0); exp_pc += 32'd4;
    step();
    exp_skip = exp_skip + 16'd1;
    chk("t3_fail_issue", 32'(issue_valid), 32'd0);
    chk("t3_fail_skip",  32'(skip_cnt),    32'(exp_skip));
    chk("t3_fail_req",   32'(imem_req),    32'd1);
    chk("t3_fail_addr",  imem_addr,        exp_pc);
    nzcv = 4'b0100;
    fetch(32'h0A000000, 0); exp_pc += 32'd4;
    step();
    chk("t3_pass_issue", 32'(issue_valid), 32'd1);
    chk("t3_pass_fam",   32'(family_bits), 32'h0200);
    chk("t3_pass_skip",  32'(skip_cnt),    32'(exp_skip));
    finish_issue();
    chk("t3_next_addr",  imem_addr,        exp_pc);

    // family classification sweep
    for (int i = 0; i < 12; i++) begin
      fetch(sw_word[i], 0); exp_pc += 32'd4;
      step();
      chk($sformatf("t4_fam_%08h", sw_word[i]), 32'(family_bits), 32'(sw_fam[i]));
      finish_issue();
      chk($sformatf("t4_addr_%0d", i), imem_addr, exp_pc);
    end

    // NV condition is never executed
    fetch(32'hF3A00001, 0); exp_pc += 32'd4;
    step();
    exp_skip = exp_skip + 16'd1;
    chk("nv_issue", 32'(issue_valid), 32'd0);
    chk("nv_skip",  32'(skip_cnt),    32'(exp_skip));

    // condition table
    for (int i = 0; i < 16; i++) begin
      nzcv = cv_nzcv[i];
      fetch({cv_cond[i], 28'hA000000}, 0); exp_pc += 32'd4;
      step();
      chk($sformatf("cond_%0h_nzcv_%04b", cv_cond[i], cv_nzcv[i]), 32'(issue_valid), 32'(cv_pass[i]));
      if (cv_pass[i]) finish_issue();
      else exp_skip = exp_skip + 16'd1;
    end
    chk("cond_skip", 32'(skip_cnt), 32'(exp_skip));
    chk("cond_addr", imem_addr,     exp_pc);

    // redirect in FETCH before ack: latched, address held, word discarded
    nzcv = 4'b0000;
    pc_load = 1'b1; pc_load_val = 32'h0000_0103;
    step();
    pc_load = 1'b0;
    chk("t5_hold_addr", imem_addr,     exp_pc);
    chk("t5_hold_req",  32'(imem_req), 32'd1);
    step();
    chk("t5_hold2_addr", imem_addr, exp_pc);
    fetch(32'hE3A00001, 0);
    chk("t5_disc_req",   32'(imem_req),    32'd1);
    chk("t5_disc_addr",  imem_addr,        32'h100);
    chk("t5_disc_issue", 32'(issue_valid), 32'd0);
    step();
    chk("t5_disc2_req",   32'(imem_req),    32'd1);
    chk("t5_disc2_issue", 32'(issue_valid), 32'd0);

    // redirect in the same cycle as ack
    imem_ack = 1'b1; imem_rdata = 32'hE3A00001;
    pc_load = 1'b1; pc_load_val = 32'h0000_0140;
    step();
    imem_ack = 1'b0; pc_load = 1'b0;
    chk("t5b_req",  32'(imem_req), 32'd1);
    chk("t5b_addr", imem_addr,     32'h140);
    step();
    chk("t5b_issue", 32'(issue_valid), 32'd0);

    // redirect together with uc_done
    fetch(32'hE3A00001, 0);
    step();
    chk("t6_issue", 32'(issue_valid), 32'd1);
    pc_load = 1'b1; pc_load_val = 32'h0000_0200; uc_done = 1'b1;
    step();
    pc_load = 1'b0; uc_done = 1'b0;
    chk("t6_req",   32'(imem_req),    32'd1);
    chk("t6_addr",  imem_addr,        32'h200);
    chk("t6_issue_off", 32'(issue_valid), 32'd0);

    // redirect during COND keeps the pass decision
    fetch(32'hE3A00001, 0);
    pc_load = 1'b1; pc_load_val = 32'h0000_0300;
    step();
    pc_load = 1'b0;
    chk("t6c_issue", 32'(issue_valid), 32'd1);
    chk("t6c_fam",   32'(family_bits), 32'h0020);
    chk("t6c_pc",    pc,               32'h300);
    finish_issue();
    chk("t6c_addr",  imem_addr,        32'h300);

    // skip counter saturation, preloaded just below the ceiling
    force dut.skip_cnt = 16'hFFFE;
    step();
    step();
    release dut.skip_cnt;
    chk("sat_pre", 32'(skip_cnt), 32'h0000_FFFE);
    nzcv = 4'b0000;
    fetch(32'h0A000000, 0);
    step();
    chk("sat_hit",  32'(skip_cnt), 32'h0000_FFFF);
    fetch(32'h0A000000, 0);
    step();
    chk("sat_hold", 32'(skip_cnt), 32'h0000_FFFF);
    chk("sat_addr", imem_addr,     32'h308);

    // asynchronous reset mid-issue
    fetch(32'hE3A00001, 0);
    step();
    chk("mrst_busy", 32'(issue_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_req",   32'(imem_req),    32'd0);
    chk("mrst_issue", 32'(issue_valid), 32'd0);
    chk("mrst_fam",   32'(family_bits), 32'd0);
    chk("mrst_skip",  32'(skip_cnt),    32'd0);
    chk("mrst_pc",    pc,               32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mrst_rel_req",  32'(imem_req), 32'd1);
    chk("mrst_rel_addr", imem_addr,     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
